// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: frame layout, idle frame and framer states.
package uart_pkg;

  localparam int unsigned FRAME_W    = 9;
  localparam int unsigned DATA_W     = 7;
  localparam int unsigned STOP_POS   = 8;
  localparam int unsigned PARITY_POS = 7;

  localparam logic [FRAME_W-1:0] IDLE_FRAME = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async rx line plus a history flop for falling-edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic fall_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resync chain; resets to the idle (high) line level so no edge is seen on release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_sync_o = sync_q;
  assign fall_c    = !sync_q && prev_q;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: start-bit detect, mid-bit sampling of 9 bits, one-cycle load strobe.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic [FRAME_W-1:0] frame_out,
  output logic               load,
  output logic               busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W    = 4;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_W - 1);

  logic rx_sync;
  logic fall;

  rx_state_e          state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [FRAME_W-1:0] shreg_q,  shreg_d;
  logic               load_q,   load_d;
  logic               busy_q,   busy_d;

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .rx_i      (rx),
    .rx_sync_o (rx_sync),
    .fall_c    (fall)
  );

  // State and datapath registers; a reset mid-frame drops the partial frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= IDLE_FRAME;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state: half-bit to start centre, then full-bit steps to each data/parity/stop centre.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = rx_sync ? IDLE : SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q == BIT_LAST) begin
          shreg_d = {rx_sync, shreg_q[FRAME_W-1:1]};
          cnt_d   = '0;
          if (bitcnt_q == LAST_BIT) begin
            state_d = DONE;
          end else begin
            bitcnt_d = bitcnt_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    load_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  assign frame_out = shreg_q;
  assign load      = load_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: vector table, corner sequences and random waveforms.
module tb_uart_rx_framer;
  import uart_pkg::*;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;
  localparam int          MAXN = 4096;
  localparam int          LAT  = 2 + HALF + 9 * CPB;

  logic               clk = 1'b0;
  logic               reset;
  logic               rx;
  logic [FRAME_W-1:0] frame_out;
  logic               load;
  logic               busy;

  always #5 clk = ~clk;

  uart_rx_framer #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .frame_out (frame_out),
    .load      (load),
    .busy      (busy)
  );

  typedef struct {
    logic [6:0]         data;
    logic               par;
    logic               stop;
    logic [FRAME_W-1:0] exp_frame;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic pin  [MAXN];
  logic rstv [MAXN];
  int   wp;

  int                 obs_edge  [$];
  logic [FRAME_W-1:0] obs_frame [$];
  logic               obs_busy  [MAXN];
  int                 exp_edge  [$];
  logic [FRAME_W-1:0] exp_frame [$];
  logic               exp_busy  [MAXN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      if (wp < MAXN) begin
        pin[wp]  = b;
        rstv[wp] = 1'b1;
        wp++;
      end
    end
  endtask

  task automatic push_frame(input logic [6:0] d, input logic p, input logic s);
    push(1'b0, CPB);
    for (int j = 0; j < 7; j++) push(d[j], CPB);
    push(p, CPB);
    push(s, CPB);
  endtask

  // Apply pin[n]/rstv[n] so they are seen at clock edge n; record outputs just after each edge.
  task automatic drive(input int len);
    obs_edge.delete();
    obs_frame.delete();
    for (int n = 0; n < len; n++) begin
      rx    = pin[n];
      reset = rstv[n];
      @(posedge clk);
      #1;
      obs_busy[n] = busy;
      if (load !== 1'b0) begin
        obs_edge.push_back(n);
        obs_frame.push_back(frame_out);
      end
    end
    reset = 1'b1;
  endtask

  // Reference: a start is a high->low pin transition at t while receiver is free;
  // it is accepted if the pin is still low at t+HALF; bit j is the pin at t+HALF+(j+1)*CPB.
  function automatic void model(input int len);
    int t, ready, endb, lsamp;
    logic [FRAME_W-1:0] fr;
    exp_edge.delete();
    exp_frame.delete();
    for (int n = 0; n < len; n++) exp_busy[n] = 1'b0;
    ready = 1;
    t     = 1;
    while (t + HALF < len) begin
      if (t >= ready && pin[t] == 1'b0 && pin[t-1] == 1'b1) begin
        if (pin[t+HALF] == 1'b0) begin
          lsamp = t + LAT;
          for (int j = 0; j < FRAME_W; j++) begin
            fr[j] = pin[(t + HALF + (j + 1) * CPB) % MAXN];
          end
          if (lsamp < len) begin
            exp_edge.push_back(lsamp);
            exp_frame.push_back(fr);
          end
          endb  = lsamp;
          ready = lsamp;
        end else begin
          endb  = t + 1 + HALF;
          ready = t + 1 + HALF;
        end
        for (int k = t + 2; k <= endb && k < len; k++) exp_busy[k] = 1'b1;
        t = ready;
      end else begin
        t++;
      end
    end
  endfunction

  task automatic compare_model(input string tag, input int len);
    int n_cmp, bad, first_bad;
    model(len);
    chk({tag, "_load_count"}, obs_edge.size(), exp_edge.size());
    n_cmp = (obs_edge.size() < exp_edge.size()) ? obs_edge.size() : exp_edge.size();
    for (int i = 0; i < n_cmp; i++) begin
      chk($sformatf("%s_load_edge%0d", tag, i), obs_edge[i], exp_edge[i]);
      chk($sformatf("%s_frame%0d", tag, i), obs_frame[i], exp_frame[i]);
    end
    bad       = 0;
    first_bad = -1;
    for (int n = 0; n < len; n++) begin
      if (obs_busy[n] !== exp_busy[n]) begin
        if (first_bad < 0) first_bad = n;
        bad++;
      end
    end
    if (bad != 0) $display("  %s busy trace differs first at cycle %0d", tag, first_bad);
    chk({tag, "_busy_trace_errors"}, bad, 0);
  endtask

  vec_t vecs [6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [FRAME_W-1:0] last_frame;
    int rst_idx;

    vecs[0] = '{data: 7'h41, par: 1'b0, stop: 1'b1, exp_frame: 9'h141};
    vecs[1] = '{data: 7'h7F, par: 1'b1, stop: 1'b0, exp_frame: 9'h0FF};
    vecs[2] = '{data: 7'h00, par: 1'b1, stop: 1'b1, exp_frame: 9'h180};
    vecs[3] = '{data: 7'h2A, par: 1'b1, stop: 1'b1, exp_frame: 9'h1AA};
    vecs[4] = '{data: 7'h55, par: 1'b0, stop: 1'b1, exp_frame: 9'h155};
    vecs[5] = '{data: 7'h41, par: 1'b0, stop: 1'b1, exp_frame: 9'h141};

    // Reset held low for 3 cycles with idle line, then released.
    reset = 1'b0;
    rx    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_frame%0d", i), frame_out, IDLE_FRAME);
      chk($sformatf("rst_load%0d", i), load, 1'b0);
      chk($sformatf("rst_busy%0d", i), busy, 1'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_frame%0d", i), frame_out, IDLE_FRAME);
      chk($sformatf("idle_load%0d", i), load, 1'b0);
      chk($sformatf("idle_busy%0d", i), busy, 1'b0);
    end

    // Single frames from the vector table; start edge at cycle 4.
    for (int v = 0; v < 6; v++) begin
      wp = 0;
      push(1'b1, 4);
      push_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
      push(1'b1, 24);
      drive(wp);
      chk($sformatf("vec%0d_loads", v), obs_edge.size(), 1);
      if (obs_edge.size() >= 1) begin
        chk($sformatf("vec%0d_edge", v), obs_edge[0], 4 + 154);
        chk($sformatf("vec%0d_frame", v), obs_frame[0], vecs[v].exp_frame);
        chk($sformatf("vec%0d_busy_after", v), obs_busy[obs_edge[0] + 1], 1'b0);
      end
      compare_model($sformatf("vec%0d", v), wp);
    end
    last_frame = vecs[5].exp_frame;

    // Short low glitch: rejected at start mid-sample, frame_out untouched.
    wp = 0;
    push(1'b1, 4);
    push(1'b0, 3);
    push(1'b1, 30);
    drive(wp);
    chk("glitch_loads", obs_edge.size(), 0);
    chk("glitch_busy_t9", obs_busy[4 + 9], 1'b1);
    chk("glitch_busy_t10", obs_busy[4 + 10], 1'b0);
    chk("glitch_frame", frame_out, last_frame);
    compare_model("glitch", wp);

    // Stop bit 0 then line held low: one frame, nothing more until rx rises and falls.
    wp = 0;
    push(1'b1, 4);
    push_frame(7'h7F, 1'b1, 1'b0);
    push(1'b0, 40);
    push(1'b1, 10);
    push_frame(7'h41, 1'b0, 1'b1);
    push(1'b1, 24);
    drive(wp);
    chk("brk_loads", obs_edge.size(), 2);
    if (obs_edge.size() == 2) begin
      chk("brk_frame0", obs_frame[0], 9'h0FF);
      chk("brk_edge0", obs_edge[0], 4 + 154);
      chk("brk_frame1", obs_frame[1], 9'h141);
      chk("brk_edge1", obs_edge[1], 4 + 160 + 40 + 10 + 154);
    end
    compare_model("brk", wp);

    // Back-to-back frames with no idle gap.
    wp = 0;
    push(1'b1, 4);
    push_frame(7'h30, 1'b0, 1'b1);
    push_frame(7'h39, 1'b0, 1'b1);
    push(1'b1, 24);
    drive(wp);
    chk("b2b_loads", obs_edge.size(), 2);
    if (obs_edge.size() == 2) begin
      chk("b2b_spacing", obs_edge[1] - obs_edge[0], 160);
      chk("b2b_frame0", obs_frame[0], 9'h130);
      chk("b2b_frame1", obs_frame[1], 9'h139);
    end
    compare_model("b2b", wp);

    // Reset during data bit 4 of a frame of 7'h55.
    wp = 0;
    push(1'b1, 4);
    push(1'b0, CPB);
    push(1'b1, CPB);
    push(1'b0, CPB);
    push(1'b1, CPB);
    push(1'b0, CPB);
    push(1'b1, HALF);
    rst_idx = wp;
    push(1'b1, 3);
    for (int i = 0; i < 3; i++) rstv[rst_idx + i] = 1'b0;
    push(1'b1, 24);
    drive(wp);
    chk("midrst_busy_before", obs_busy[rst_idx - 1], 1'b1);
    chk("midrst_loads", obs_edge.size(), 0);
    chk("midrst_frame", frame_out, IDLE_FRAME);
    chk("midrst_busy", busy, 1'b0);
    wp = 0;
    push(1'b1, 4);
    push_frame(7'h55, 1'b0, 1'b1);
    push(1'b1, 24);
    drive(wp);
    chk("postrst_loads", obs_edge.size(), 1);
    if (obs_edge.size() == 1) chk("postrst_frame", obs_frame[0], 9'h155);
    compare_model("postrst", wp);

    // Random frames, glitches and gaps against the reference model.
    for (int r = 0; r < 4; r++) begin
      wp = 0;
      push(1'b1, 4);
      for (int f = 0; f < 8; f++) begin
        if ($urandom_range(0, 5) == 0) begin
          push(1'b0, $urandom_range(1, 6));
          push(1'b1, $urandom_range(1, 12));
        end else begin
          push_frame(7'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0));
          push(1'b1, $urandom_range(0, 12));
        end
      end
      push(1'b1, 24);
      drive(wp);
      compare_model($sformatf("rand%0d", r), wp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Serial front end of the UART receiver.
- Synchronises the asynchronous rx line and detects a start bit, then samples 7 data bits, 1 parity bit and 1 stop bit at mid-bit.
- Assembles the 9-bit frame and issues a one-cycle load strobe to the downstream receive data register.
- Does no parity or stop-bit checking; the downstream error detector does that.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per bit period (50 MHz / 9600 baud); legal range >= 4
HALF_BIT, CLKS_PER_BIT/2, cycles from start-bit falling edge to start-bit mid-sample

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
rx  input  1  asynchronous serial line, idle high
frame_out  output  9  assembled frame: [8]=stop, [7]=parity, [6:0]=data (LSB received first)
load  output  1  one-cycle strobe; frame_out valid while high
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (clk edge with reset low):
  - state=IDLE; frame_out=9'h1FF; load=0; busy=0.
  - Baud and bit counters cleared.
  - Synchroniser flops and edge-history flop set to 1.
  - Reset mid-frame discards the partial frame; no load is issued.
- Synchroniser: 2 flops give rx_sync. A third flop gives rx_prev. fall = rx_sync==0 && rx_prev==1.
- IDLE: on fall, go to START with cnt=0. Otherwise stay. A low line with no falling edge never starts a frame (break / stuck-low safe).
- START:
  - cnt increments each cycle.
  - When cnt==HALF_BIT-1: if rx_sync==0, go to SHIFT with cnt=0 and bitcnt=0. Otherwise go to IDLE (glitch rejected, no load).
- SHIFT:
  - cnt increments each cycle.
  - When cnt==CLKS_PER_BIT-1: shift right, shreg <= {rx_sync, shreg[8:1]}, and set cnt=0.
  - If bitcnt==8, go to DONE. Otherwise bitcnt++.
  - After 9 samples: shreg[0]=first data bit, shreg[8]=stop bit.
- DONE: load=1 for exactly this one cycle, then IDLE unconditionally.
- frame_out:
  - Driven continuously from shreg.
  - shreg is modified only in SHIFT, so frame_out is stable from DONE until the first data sample of the next frame.
- Stop bit sampled 0: frame still delivered with frame_out[8]=0 and load pulses. A new frame needs rx to return high and then fall.
- Latency: let t0 be the first clk edge at which the rx pin is low.
  - Start detected at edge t0+2.
  - Start mid-sample at edge t0+2+HALF_BIT.
  - Data sample j (0..8) at edge t0+2+HALF_BIT+(j+1)*CLKS_PER_BIT.
  - load is high in the cycle after edge t0+2+HALF_BIT+9*CLKS_PER_BIT.
- Back-to-back frames need no idle gap: IDLE is re-entered about HALF_BIT-1 cycles before the stop bit ends.
- Counter widths: cnt is $clog2(CLKS_PER_BIT) bits; bitcnt is 4 bits. No wrap is possible because every compare is exact.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, SHIFT, DONE);
  - FRAME_W=9, DATA_W=7;
  - STOP_POS=8, PARITY_POS=7;
  - IDLE_FRAME=9'h1FF.
  - The downstream data register and error detector share these.
- Sub-module uart_rx_sync: 2-flop synchroniser plus rx_prev flop. Outputs rx_sync and fall; reset value 1.

Test Plan (CLKS_PER_BIT=16, HALF_BIT=8):
- Reset held low 3 cycles, rx=1 -> frame_out=9'h1FF, load=0, busy=0 throughout, and after release with rx idle.
- Serial start, data 7'h41 LSB first, parity 0, stop 1 -> frame_out=9'h141, load high for exactly one cycle after edge t0+154, busy low next cycle.
- rx low for 3 cycles then high -> FSM returns to IDLE at edge t0+10, no load, frame_out unchanged.
- Data 7'h7F, parity 1, stop 0, then rx held low 40 cycles -> one load with frame_out=9'h0FF, no second frame until rx rises and falls again.
- Frames 7'h30/p0/s1 and 7'h39/p0/s1 sent with zero gap -> two load pulses exactly 160 cycles apart, carrying 9'h130 then 9'h139.
- Reset asserted during data bit 4 of a frame -> no load, frame_out=9'h1FF. A following complete frame 7'h55/p0/s1 yields 9'h155.
